// File: rtl/svo_pattern_gen.sv
// rtl/svo_pattern_gen.sv - parametrised test-pattern pixel source (overlay, bars, checker, solid)
// Three-stage stall-safe pipeline: S0 cursor/ROM address, S1 ROM data plus sideband, S2 output register.
module svo_pattern_gen #(
  parameter int HOR_PIXELS      = 640,
  parameter int VER_PIXELS      = 480,
  parameter int XYBITS          = 12,
  parameter int CBITS           = 8,
  parameter int WIN_X0          = 160,
  parameter int WIN_Y0          = 0,
  parameter int WIN_W           = 320,
  parameter int WIN_H           = 480,
  parameter int ROM_AW          = 18,
  parameter int IDX_BITS        = 2,
  parameter int PAL_STEP        = 50,
  parameter int STEP            = 1,
  parameter int FRAMES_PER_STEP = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [1:0]           mode,
  output logic [ROM_AW-1:0]    rom_addr,
  output logic                 rom_ce,
  input  logic [IDX_BITS-1:0]  rom_data,
  output logic                 out_axis_tvalid,
  input  logic                 out_axis_tready,
  output logic [3*CBITS-1:0]   out_axis_tdata,
  output logic                 out_axis_tuser
);

  localparam logic [CBITS-1:0]  MAX      = {CBITS{1'b1}};
  localparam logic [CBITS-1:0]  STEP_C   = CBITS'(STEP);
  localparam logic [XYBITS-1:0] H_LAST   = XYBITS'(HOR_PIXELS - 1);
  localparam logic [XYBITS-1:0] V_LAST   = XYBITS'(VER_PIXELS - 1);
  localparam logic [XYBITS-1:0] WX0      = XYBITS'(WIN_X0);
  localparam logic [XYBITS-1:0] WY0      = XYBITS'(WIN_Y0);
  localparam logic [XYBITS-1:0] WW       = XYBITS'(WIN_W);
  localparam logic [XYBITS-1:0] WH       = XYBITS'(WIN_H);
  localparam int                DIV_W    = $clog2(FRAMES_PER_STEP + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(FRAMES_PER_STEP - 1);
  localparam int                PW       = IDX_BITS + 32;

  typedef enum logic [1:0] {RED, GREEN, BLUE} phase_t;

  phase_t              phase;
  logic [CBITS-1:0]    intensity;
  logic [DIV_W-1:0]    frame_div;
  logic [XYBITS-1:0]   hcur, vcur, dx, dy;
  logic [ROM_AW-1:0]   waddr;
  logic [1:0]          mode_q, frame_mode;
  logic                adv, s0_sof, s0_last, s0_win;
  logic                s1_valid, s1_win, s1_sof, s1_y5;
  logic [XYBITS-1:0]   s1_x;
  logic [1:0]          s1_mode;
  logic [3*CBITS-1:0]  s1_bg, bg, pix;
  logic [PW-1:0]       pal_prod;
  logic [CBITS-1:0]    pal_b;
  logic [2:0]          bar_k;

  assign adv     = !out_axis_tvalid || out_axis_tready;
  assign rom_ce  = adv;
  assign s0_sof  = (hcur == '0) && (vcur == '0);
  assign s0_last = (hcur == H_LAST) && (vcur == V_LAST);
  // Left of / above the window the subtraction wraps past WIN_W/WIN_H, so one compare per axis suffices.
  assign dx       = hcur - WX0;
  assign dy       = vcur - WY0;
  assign s0_win   = (dx < WW) && (dy < WH);
  assign rom_addr = s0_win ? waddr : '0;
  assign frame_mode = s0_sof ? mode : mode_q;

  always_comb begin
    bg = '0;
    case (phase)
      GREEN:   bg = {MAX - intensity, intensity, CBITS'(0)};
      BLUE:    bg = {intensity, CBITS'(0), MAX - intensity};
      default: bg = {CBITS'(0), MAX - intensity, intensity};
    endcase
  end

  always_comb begin
    pal_prod = PW'(rom_data) * PW'(PAL_STEP);
    pal_b    = (pal_prod > PW'(MAX)) ? MAX : pal_prod[CBITS-1:0];
    bar_k    = 3'd0;
    for (int j = 1; j < 8; j++) begin
      if (s1_x >= XYBITS'(j * (HOR_PIXELS / 8))) bar_k = bar_k + 3'd1;
    end
    pix = s1_bg;
    case (s1_mode)
      2'd0:    pix = (s1_win && rom_data != '0) ? {pal_b, CBITS'(0), CBITS'(0)} : s1_bg;
      2'd1:    pix = {{CBITS{bar_k[2]}}, {CBITS{bar_k[1]}}, {CBITS{bar_k[0]}}};
      2'd2:    pix = (s1_x[5] ^ s1_y5) ? s1_bg : '0;
      default: pix = s1_bg;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hcur            <= '0;
      vcur            <= '0;
      waddr           <= '0;
      mode_q          <= '0;
      s1_valid        <= 1'b0;
      s1_win          <= 1'b0;
      s1_sof          <= 1'b0;
      s1_y5           <= 1'b0;
      s1_x            <= '0;
      s1_mode         <= '0;
      s1_bg           <= '0;
      out_axis_tvalid <= 1'b0;
      out_axis_tdata  <= '0;
      out_axis_tuser  <= 1'b0;
      frame_div       <= '0;
      phase           <= RED;
      intensity       <= MAX;
    end else if (adv) begin
      hcur <= (hcur == H_LAST) ? '0 : hcur + XYBITS'(1);
      if (hcur == H_LAST) vcur <= (vcur == V_LAST) ? '0 : vcur + XYBITS'(1);
      if (s0_last)     waddr <= '0;
      else if (s0_win) waddr <= waddr + ROM_AW'(1);
      mode_q   <= frame_mode;
      s1_valid <= 1'b1;
      s1_win   <= s0_win;
      s1_sof   <= s0_sof;
      s1_y5    <= vcur[5];
      s1_x     <= hcur;
      s1_mode  <= frame_mode;
      // bg travels with the pixel so the last pixel of a frame keeps that frame's colour.
      s1_bg    <= bg;
      out_axis_tvalid <= s1_valid;
      out_axis_tdata  <= pix;
      out_axis_tuser  <= s1_valid && s1_sof;
      if (s0_last) begin
        if (frame_div == DIV_LAST) begin
          frame_div <= '0;
          if (intensity >= STEP_C && intensity != '0) begin
            intensity <= intensity - STEP_C;
          end else begin
            intensity <= MAX;
            case (phase)
              RED:     phase <= GREEN;
              GREEN:   phase <= BLUE;
              default: phase <= RED;
            endcase
          end
        end else begin
          frame_div <= frame_div + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_svo_pattern_gen.sv
// tb/tb_svo_pattern_gen.sv - self-checking bench for svo_pattern_gen on a reduced 64x4 geometry
module tb_svo_pattern_gen;
  localparam int H = 64, V = 4, XB = 8, CB = 4, WX0 = 16, WY0 = 1, WW = 32, WH = 2;
  localparam int RAW = 8, IB = 2, PS = 6, MAXC = 15, FR = H * V;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [1:0]      mode = 2'd3;
  logic [RAW-1:0]  rom_addr;
  logic            rom_ce;
  logic [IB-1:0]   rom_data = '0;
  logic            tvalid;
  logic            tready = 1'b1;
  logic [3*CB-1:0] tdata;
  logic            tuser;

  int errors = 0;
  int checks = 0;

  svo_pattern_gen #(
    .HOR_PIXELS(H), .VER_PIXELS(V), .XYBITS(XB), .CBITS(CB),
    .WIN_X0(WX0), .WIN_Y0(WY0), .WIN_W(WW), .WIN_H(WH),
    .ROM_AW(RAW), .IDX_BITS(IB), .PAL_STEP(PS), .STEP(1), .FRAMES_PER_STEP(1)
  ) dut (
    .clk(clk), .resetn(resetn), .mode(mode),
    .rom_addr(rom_addr), .rom_ce(rom_ce), .rom_data(rom_data),
    .out_axis_tvalid(tvalid), .out_axis_tready(tready),
    .out_axis_tdata(tdata), .out_axis_tuser(tuser)
  );

  always #5 clk = ~clk;

  // Synchronous ROM holding (addr mod 4), frozen while rom_ce is low
  always @(posedge clk) if (rom_ce) rom_data <= rom_addr[1:0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] bg_of(input int f);
    int i, ph, r, g, b;
    i  = MAXC - (f % (MAXC + 1));
    ph = (f / (MAXC + 1)) % 3;
    if (ph == 0)      begin r = i;        g = MAXC - i; b = 0;        end
    else if (ph == 1) begin r = 0;        g = i;        b = MAXC - i; end
    else              begin r = MAXC - i; g = 0;        b = i;        end
    return 12'(b * 256 + g * 16 + r);
  endfunction

  function automatic int win_addr(input int x, input int y);
    if (x >= WX0 && x < WX0 + WW && y >= WY0 && y < WY0 + WH) return (y - WY0) * WW + (x - WX0);
    return -1;
  endfunction

  function automatic logic [11:0] model_pix(input int idx, input int m);
    int f, x, y, a, k, b;
    f = idx / FR;
    x = (idx % FR) % H;
    y = (idx % FR) / H;
    if (m == 0) begin
      a = win_addr(x, y);
      if (a >= 0 && (a % 4) != 0) begin
        b = (a % 4) * PS;
        if (b > MAXC) b = MAXC;
        return 12'(b * 256);
      end
      return bg_of(f);
    end else if (m == 1) begin
      k = x / (H / 8);
      if (k > 7) k = 7;
      return 12'(((k >> 2) & 1) * MAXC * 256 + ((k >> 1) & 1) * MAXC * 16 + (k & 1) * MAXC);
    end else if (m == 2) begin
      return (((x >> 5) ^ (y >> 5)) & 1) != 0 ? bg_of(f) : 12'h000;
    end
    return bg_of(f);
  endfunction

  int          s0_idx = 0, out_idx = 0;
  int          fmode[$];
  logic [11:0] cap[int];
  int          addr_cap[int];
  logic        prev_stall = 1'b0;
  logic [11:0] prev_data;
  logic        prev_user;

  always @(negedge clk) begin
    int p, a, f;
    if (!resetn) begin
      check("reset_tvalid", 32'(tvalid), 32'd0);
      check("reset_tdata", 32'(tdata), 32'd0);
      check("reset_tuser", 32'(tuser), 32'd0);
      s0_idx = 0; out_idx = 0; prev_stall = 1'b0;
      fmode.delete(); cap.delete(); addr_cap.delete();
    end else begin
      p = s0_idx % FR;
      a = win_addr(p % H, p / H);
      check("rom_addr", 32'(rom_addr), (a < 0) ? 32'd0 : 32'(a));
      check("rom_ce", 32'(rom_ce), 32'(!tvalid || tready));
      addr_cap[s0_idx] = int'(rom_addr);
      if (rom_ce) begin
        if (p == 0) fmode.push_back(int'(mode));
        s0_idx++;
      end
      if (prev_stall) begin
        check("stall_tdata", 32'(tdata), 32'(prev_data));
        check("stall_tuser", 32'(tuser), 32'(prev_user));
      end
      if (tvalid) begin
        f = out_idx / FR;
        if (f >= fmode.size()) begin
          checks++; errors++;
          $display("FAIL beat_order: beat %0d has no frame entry in S0", out_idx);
        end else begin
          check("pixel", 32'(tdata), 32'(model_pix(out_idx, fmode[f])));
        end
        check("tuser", 32'(tuser), 32'(out_idx % FR == 0));
        cap[out_idx] = tdata;
        if (tready) out_idx++;
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_user  = tuser;
    end
  end

  task automatic run(input int n, input bit rnd);
    repeat (n) begin
      @(posedge clk); #2;
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic do_reset(input logic [1:0] m);
    @(posedge clk); #2;
    resetn = 1'b0; mode = m; tready = 1'b1;
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
  endtask

  task automatic lit(input string name, input int idx, input logic [11:0] exp);
    if (!cap.exists(idx)) begin
      checks++; errors++;
      $display("FAIL %s: beat %0d never captured, expected %0h", name, idx, exp);
    end else begin
      check(name, 32'(cap[idx]), 32'(exp));
    end
  endtask

  initial begin
    // Reset release latency and solid pattern
    do_reset(2'd3);
    @(negedge clk); check("lat_pre_edge1", 32'(tvalid), 32'd0);
    @(negedge clk); check("lat_after_edge1", 32'(tvalid), 32'd0);
    @(negedge clk); check("lat_after_edge2", 32'(tvalid), 32'd1);
    check("first_tuser", 32'(tuser), 32'd1);
    check("first_tdata", 32'(tdata), 32'h00F);
    run(2 * FR + 20, 1'b0);
    lit("solid_f0", 0, 12'h00F);
    lit("solid_f1", 256, 12'h01E);
    lit("solid_f1_last", 511, 12'h01E);

    // Overlay with random backpressure
    do_reset(2'd0);
    run(3 * FR, 1'b1);
    lit("ovl_x15", 79, 12'h00F);
    lit("ovl_x16_idx0", 80, 12'h00F);
    lit("ovl_x17", 81, 12'h600);
    lit("ovl_x18", 82, 12'hC00);
    lit("ovl_x19_clamp", 83, 12'hF00);
    lit("ovl_x48", 112, 12'h00F);
    check("waddr_16_2", 32'(addr_cap[144]), 32'd32);
    check("waddr_19_1", 32'(addr_cap[83]), 32'd3);

    // Colour cycle through a full RED->GREEN->BLUE->RED wrap
    do_reset(2'd3);
    run(49 * FR + 10, 1'b0);
    lit("cyc_f15", 15 * FR, 12'h0F0);
    lit("cyc_f16", 16 * FR, 12'h0F0);
    lit("cyc_f17", 17 * FR, 12'h1E0);
    lit("cyc_f32", 32 * FR, 12'hF00);
    lit("cyc_f47", 47 * FR, 12'h00F);
    lit("cyc_f48", 48 * FR, 12'h00F);

    // Mode change mid-frame, bars -> checker
    do_reset(2'd1);
    for (int i = 0; i < 2000 && s0_idx < 130; i++) @(posedge clk);
    #2 mode = 2'd2;
    checks++;
    if (s0_idx < 130) begin
      errors++;
      $display("FAIL mode_wait: s0 index %0d never reached 130", s0_idx);
    end
    run(4 * FR, 1'b1);
    lit("bar_k1", 8, 12'h00F);
    lit("bar_k3", 24, 12'h0FF);
    lit("bar_k5_line3", 3 * H + 40, 12'hF0F);
    lit("bar_k7_line3", 3 * H + 56, 12'hFFF);
    lit("chk_0_0", 256, 12'h000);
    lit("chk_31_0", 287, 12'h000);
    lit("chk_32_0", 288, 12'h01E);

    // Asynchronous reset mid-line, then restart
    run(5, 1'b0);
    @(posedge clk); #2;
    check("pre_reset_tvalid", 32'(tvalid), 32'd1);
    resetn = 1'b0; mode = 2'd3;
    #1;
    check("async_tvalid", 32'(tvalid), 32'd0);
    check("async_tdata", 32'(tdata), 32'd0);
    check("async_tuser", 32'(tuser), 32'd0);
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    run(FR + 10, 1'b0);
    lit("restart_first", 0, 12'h00F);
    lit("restart_last", 255, 12'h00F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/svo_pattern_gen.md
Name: svo_pattern_gen

Overview:
- Parametrised successor of the SVO test-card source: emits one AXI-stream pixel stream per frame, selectable among four patterns.
- Generalises geometry, colour depth, overlay window, palette and colour-cycle rate.
- Accounts for synchronous-ROM latency with a stall-safe pipeline.
- Sits upstream of the SVO encoder/timing chain, in place of the fixed test card.

Parameters:
HOR_PIXELS, 640, active pixels per line
VER_PIXELS, 480, active lines per frame
XYBITS, 12, cursor width; must satisfy 2^XYBITS > max(HOR_PIXELS, VER_PIXELS)
CBITS, 8, bits per colour channel; pixel width is 3*CBITS
WIN_X0, 160, overlay window left column
WIN_Y0, 0, overlay window top line
WIN_W, 320, overlay window width
WIN_H, 480, overlay window height
ROM_AW, 18, overlay ROM address width; WIN_W*WIN_H <= 2^ROM_AW
IDX_BITS, 2, overlay ROM data (palette index) width
PAL_STEP, 50, blue increment per palette index
STEP, 1, colour-cycle intensity decrement per update
FRAMES_PER_STEP, 1, frames between colour-cycle updates (>=1)

Ports:
clk  in  1  pixel clock
resetn  in  1  asynchronous active-low reset
mode  in  2  pattern select: 0 overlay, 1 bars, 2 checker, 3 solid
rom_addr  out  ROM_AW  overlay ROM address
rom_ce  out  1  ROM clock enable; ROM holds rom_data when low
rom_data  in  IDX_BITS  ROM output, registered, 1-cycle latency
out_axis_tvalid  out  1  pixel valid
out_axis_tready  in  1  downstream ready
out_axis_tdata  out  3*CBITS  pixel {b,g,r}
out_axis_tuser  out  1  start of frame, set on pixel (0,0)

Behaviour:
- Reset: asynchronous, active-low; polarity and synchronicity fixed.
  - Values while resetn low: out_axis_tvalid=0, tdata=0, tuser=0, cursors=0, pipeline valids=0, window address counter=0, frame divider=0, phase=RED, intensity=2^CBITS-1, latched mode=0.
- Advance: adv = !out_axis_tvalid || out_axis_tready. rom_ce = adv. All pipeline registers update only when adv=1.
  - While tvalid=1 and tready=0, tdata and tuser hold stable.
- Pipeline:
  - S0: cursor presents rom_addr.
  - S1: ROM registers data; x, y, in-window flag and SOF are registered alongside it.
  - S2: output register.
  - First tvalid=1 occurs after the 2nd rising clk edge following resetn deassertion, with tready=1 throughout.
- Cursor:
  - hcursor wraps HOR_PIXELS-1 -> 0; vcursor increments on that wrap and wraps VER_PIXELS-1 -> 0.
  - tuser=1 exactly on the (0,0) pixel.
- Window address:
  - In-window when WIN_X0 <= x < WIN_X0+WIN_W and WIN_Y0 <= y < WIN_Y0+WIN_H.
  - Address equals (y-WIN_Y0)*WIN_W + (x-WIN_X0), produced by an incremental counter (no multiplier). Counter clears at (0,0) and increments on each advanced in-window pixel.
  - Out-of-window: rom_addr=0, ROM data is ignored.
- mode is sampled only when the (0,0) pixel enters S0; a change mid-frame takes effect at the next frame.
- Colour cycle background bg: MAX=2^CBITS-1, I=intensity.
  - RED: r=I, g=MAX-I, b=0.
  - GREEN: r=0, g=I, b=MAX-I.
  - BLUE: r=MAX-I, g=0, b=I.
  - bg is combinational from the current phase/intensity.
- Update event: fires when the last pixel (HOR-1,VER-1) advances out of S0 and the frame divider reaches FRAMES_PER_STEP-1; the divider then clears.
  - If I>=STEP and I!=0: I -= STEP.
  - Otherwise: I=MAX and phase advances RED->GREEN->BLUE->RED.
  - No underflow wrap.
- Pixel per latched mode:
  - 0 overlay: in-window and idx!=0 -> r=0, g=0, b=min(idx*PAL_STEP, MAX); otherwise bg.
  - 1 bars: 8 vertical bars of width HOR_PIXELS/8 (last bar absorbs the remainder). Bar k (0..7) colour is {b,g,r} = MAX*{k[2],k[1],k[0]}.
  - 2 checker: 32x32 squares. x[5]^y[5] = 1 -> bg; 0 -> black.
  - 3 solid: bg everywhere.

Test Plan:
- Reset release, tready=1, mode=3: tvalid rises after 2nd edge. First pixel tuser=1, tdata={0,0,255}. Exactly 640*480 beats per frame, each frame beginning with tuser=1.
- tready toggled pseudo-randomly 50%: captured beat sequence (x,y order, tuser positions) is identical to the tready=1 run. tdata never changes while tvalid=1 and tready=0.
- mode=0, ROM model with data=(addr mod 4):
  - x=159 -> bg.
  - x=160,y=0 -> addr 0 -> bg.
  - x=161 -> b=50.
  - x=163 -> b=150.
  - x=480 -> bg.
  - Window address at (160,1) = 320.
- Colour cycle, STEP=1, FRAMES_PER_STEP=1: frame n (n<=255) uses I=255-n. Frame 256 shows GREEN phase with I=255, i.e. {b,g,r}={0,255,0}. Full wrap back to RED after 768 frames.
- Change mode 1->2 at line 100: remainder of frame stays bars, next frame is checker. Pixel (32,0) = bg, pixel (0,0) = black.
- resetn asserted mid-line with tvalid=1: outputs zero immediately (asynchronous). After release, the stream restarts at (0,0) with tuser=1, RED phase, I=255.
